// File: rtl/demux_01x_32_reg_pkg.sv
// demux_01x_32_reg_pkg: route codes, slot state and default width shared by the demux slice
package demux_01x_32_reg_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int DROP_CNT_W_DEF = 8;
  localparam logic [1:0] SEL_CH0 = 2'd0;
  localparam logic [1:0] SEL_CH1 = 2'd1;
  localparam logic [1:0] SEL_DROP_LO = 2'd2;
  localparam logic [1:0] SEL_DROP_HI = 2'd3;
  typedef enum logic {EMPTY, FULL} slot_state_t;
  function automatic logic is_drop(input logic [1:0] sel);
    return sel >= SEL_DROP_LO && sel <= SEL_DROP_HI;
  endfunction
endpackage

// File: rtl/demux_out_slot.sv
// demux_out_slot: one-entry valid/ready holding register feeding a single sink
module demux_out_slot
  import demux_01x_32_reg_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             can_push
);
  slot_state_t st;
  assign valid = st == FULL;
  assign can_push = st == EMPTY || pop_ready;
  // a push wins over a pop, so pop+push keeps the slot FULL with fresh data
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st <= EMPTY;
      data <= '0;
    end else if (push) begin
      st <= FULL;
      data <= push_data;
    end else if (st == FULL && pop_ready) st <= EMPTY;
endmodule

// File: rtl/demux_01x_32_reg.sv
// demux_01x_32_reg: registered 1:2 valid/ready demux; sel 2/3 drops the word and counts it
module demux_01x_32_reg
  import demux_01x_32_reg_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DROP_CNT_W = DROP_CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [1:0]            in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out0_data,
  output logic                  out0_valid,
  input  logic                  out0_ready,
  output logic [WIDTH-1:0]      out1_data,
  output logic                  out1_valid,
  input  logic                  out1_ready,
  output logic                  drop_pulse,
  output logic [DROP_CNT_W-1:0] drop_count
);
  logic can0, can1, xfer, drop;
  assign in_ready = in_sel == SEL_CH0 ? can0 : in_sel == SEL_CH1 ? can1 : 1'b1;
  assign xfer = in_valid && in_ready;
  assign drop = xfer && is_drop(in_sel);
  demux_out_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk(clk), .reset(reset), .push(xfer && in_sel == SEL_CH0), .push_data(in_data),
    .pop_ready(out0_ready), .valid(out0_valid), .data(out0_data), .can_push(can0)
  );
  demux_out_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk(clk), .reset(reset), .push(xfer && in_sel == SEL_CH1), .push_data(in_data),
    .pop_ready(out1_ready), .valid(out1_valid), .data(out1_data), .can_push(can1)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      drop_pulse <= 1'b0;
      drop_count <= '0;
    end else begin
      drop_pulse <= drop;
      drop_count <= drop && drop_count != '1 ? drop_count + 1'b1 : drop_count;
    end
endmodule
